// File: rtl/hamming_ecc_arbiter.sv
// Shared SEC Hamming check-and-correct engine, two-port round-robin front end.
// Two-stage pipeline (syndrome, then correct/strip) with saturating error counters.
module hamming_ecc_arbiter #(
    parameter int CW_W   = 38,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [CW_W-1:0]   req0_cw,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [CW_W-1:0]   req1_cw,
    output logic              req1_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_corr,
    output logic              resp_uncorr,
    output logic [5:0]        resp_syn,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    function automatic logic [5:0] f_syn(input logic [CW_W-1:0] cw);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < CW_W; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (((i + 1) >> k) % 2 == 1) begin
                    s[k[2:0]] = s[k[2:0]] ^ cw[i[5:0]];
                end
            end
        end
        return s;
    endfunction

    // Data bits occupy every position that is not a power of two.
    function automatic logic [DATA_W-1:0] f_extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 0; i < CW_W; i++) begin
            if (((i + 1) & i) != 0) begin
                d[j[4:0]] = cw[i[5:0]];
                j = j + 1;
            end
        end
        return d;
    endfunction

    logic              r_last;
    logic              r_s1_valid;
    logic              r_s1_id;
    logic [CW_W-1:0]   r_s1_cw;
    logic [5:0]        r_s1_syn;
    logic              r_s2_valid;
    logic              r_s2_id;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_corr;
    logic              r_s2_uncorr;
    logic [5:0]        r_s2_syn;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    logic              w_g0;
    logic              w_g1;
    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_acc;
    logic [CW_W-1:0]   w_cw;
    logic [5:0]        w_syn;
    logic              w_flip;
    logic              w_uncorr;
    logic [CW_W-1:0]   w_mask;
    logic [CW_W-1:0]   w_fixed;
    logic              w_hs;

    assign w_g0 = req0_valid && (!req1_valid || r_last);
    assign w_g1 = req1_valid && (!req0_valid || !r_last);

    assign w_s2_load = r_s1_valid && (!r_s2_valid || resp_ready);
    assign w_s1_load = !r_s1_valid || w_s2_load;

    assign req0_ready = w_g0 && w_s1_load && !rst;
    assign req1_ready = w_g1 && w_s1_load && !rst;
    assign w_acc      = req0_ready || req1_ready;

    assign w_cw  = w_g1 ? req1_cw : req0_cw;
    assign w_syn = f_syn(w_cw);

    assign w_flip   = (r_s1_syn != 6'd0) && (r_s1_syn <= 6'd38);
    assign w_uncorr = r_s1_syn > 6'd38;
    assign w_mask   = {{(CW_W-1){1'b0}}, 1'b1} << (r_s1_syn - 6'd1);
    assign w_fixed  = w_flip ? (r_s1_cw ^ w_mask) : r_s1_cw;

    assign w_hs = r_s2_valid && resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= w_acc;
            end
            if (w_acc) begin
                r_s1_id  <= req1_ready;
                r_s1_cw  <= w_cw;
                r_s1_syn <= w_syn;
                r_last   <= req1_ready;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_id     <= 1'b0;
            r_s2_data   <= '0;
            r_s2_corr   <= 1'b0;
            r_s2_uncorr <= 1'b0;
            r_s2_syn    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid  <= 1'b1;
            r_s2_id     <= r_s1_id;
            r_s2_data   <= f_extract(w_fixed);
            r_s2_corr   <= w_flip;
            r_s2_uncorr <= w_uncorr;
            r_s2_syn    <= r_s1_syn;
        end else if (resp_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_hs) begin
            if (r_s2_corr && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (r_s2_uncorr && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

    assign resp_valid  = r_s2_valid;
    assign resp_id     = r_s2_id;
    assign resp_data   = r_s2_data;
    assign resp_corr   = r_s2_corr;
    assign resp_uncorr = r_s2_uncorr;
    assign resp_syn    = r_s2_syn;
    assign corr_cnt    = r_corr_cnt;
    assign uncorr_cnt  = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_ecc_arbiter.sv
// Randomized bench for hamming_ecc_arbiter against a position-arithmetic
// Hamming model and an in-flight queue of expected responses.
module tb_hamming_ecc_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [37:0] req0_cw;
    logic        req0_ready;
    logic        req1_valid;
    logic [37:0] req1_cw;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        resp_corr;
    logic        resp_uncorr;
    logic [5:0]  resp_syn;
    logic        clr_cnt;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    hamming_ecc_arbiter u_dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_cw     (req0_cw),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_cw     (req1_cw),
        .req1_ready  (req1_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_corr   (resp_corr),
        .resp_uncorr (resp_uncorr),
        .resp_syn    (resp_syn),
        .clr_cnt     (clr_cnt),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] d;
        logic [5:0]  syn;
        logic        c;
        logic        u;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   n_tot = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic m_last;
    int   m_cc;
    int   m_uc;

    logic        o_r0, o_r1, o_rv, o_id, o_c, o_u;
    logic [31:0] o_d;
    logic [5:0]  o_syn;
    logic [15:0] o_cc, o_uc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [37:0] enc(input logic [31:0] d);
        logic [37:0] cw;
        logic [5:0]  s;
        int j;
        cw = '0;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        s = '0;
        for (int p = 1; p <= 38; p++) if (cw[p-1]) s = s ^ 6'(p);
        for (int k = 0; k < 6; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
        return cw;
    endfunction

    function automatic ent_t model(input logic id, input logic [37:0] cw_in);
        ent_t e;
        logic [37:0] cw;
        int s;
        int j;
        cw = cw_in;
        s = 0;
        for (int p = 1; p <= 38; p++) if (cw[p-1]) s = s ^ p;
        e.id  = id;
        e.syn = 6'(s);
        e.c   = (s >= 1) && (s <= 38);
        e.u   = (s >= 39);
        if (e.c) cw[s-1] = ~cw[s-1];
        e.d = '0;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.d[j] = cw[p-1];
                j++;
            end
        end
        e.acc = cyc;
        return e;
    endfunction

    task automatic step(input logic v0, input logic [37:0] c0,
                        input logic v1, input logic [37:0] c1,
                        input logic rr, input logic clr);
        logic g0, g1, can, erv;
        @(negedge clk);
        req0_valid = v0;
        req0_cw    = c0;
        req1_valid = v1;
        req1_cw    = c1;
        resp_ready = rr;
        clr_cnt    = clr;
        #1;
        erv = (q.size() > 0) && (cyc >= q[0].acc + 2);
        g0  = v0 && (!v1 || m_last);
        g1  = v1 && (!v0 || !m_last);
        can = (q.size() < 2) || rr;
        chk("rdy0", req0_ready, g0 && can);
        chk("rdy1", req1_ready, g1 && can);
        chk("rvalid", resp_valid, erv);
        if (erv) begin
            chk("rid", resp_id, q[0].id);
            chk("rdata", resp_data, q[0].d);
            chk("rsyn", resp_syn, q[0].syn);
            chk("rcorr", resp_corr, q[0].c);
            chk("runcorr", resp_uncorr, q[0].u);
        end
        chk("ccnt", corr_cnt, m_cc);
        chk("ucnt", uncorr_cnt, m_uc);
        o_r0 = req0_ready; o_r1 = req1_ready; o_rv = resp_valid;
        o_id = resp_id; o_d = resp_data; o_syn = resp_syn;
        o_c = resp_corr; o_u = resp_uncorr; o_cc = corr_cnt; o_uc = uncorr_cnt;
        if (erv && rr) begin
            if (q[0].c && m_cc < 65535) m_cc++;
            if (q[0].u && m_uc < 65535) m_uc++;
            void'(q.pop_front());
        end
        if (clr) begin
            m_cc = 0;
            m_uc = 0;
        end
        if (g0 && can) begin
            q.push_back(model(1'b0, c0));
            m_last = 1'b0;
        end else if (g1 && can) begin
            q.push_back(model(1'b1, c1));
            m_last = 1'b1;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, 1'b0, '0, rr, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        clr_cnt    = 1'b0;
        rst        = 1'b1;
        #1;
        chk("rst_rv", resp_valid, 1'b0);
        chk("rst_r0", req0_ready, 1'b0);
        chk("rst_r1", req1_ready, 1'b0);
        chk("rst_id", resp_id, 1'b0);
        chk("rst_data", resp_data, 32'h0);
        chk("rst_flags", {resp_corr, resp_uncorr, resp_syn}, 8'h0);
        chk("rst_cnt", {corr_cnt, uncorr_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_last = 1'b1;
        m_cc = 0;
        m_uc = 0;
    endtask

    function automatic logic [37:0] rnd_cw();
        logic [63:0] r;
        logic [37:0] cw;
        cw = enc($urandom());
        case ($urandom_range(0, 3))
            1: cw[$urandom_range(0, 37)] ^= 1'b1;
            2: begin
                cw[$urandom_range(0, 37)] ^= 1'b1;
                cw[$urandom_range(0, 37)] ^= 1'b1;
            end
            3: begin
                r = {$urandom(), $urandom()};
                cw = r[37:0];
            end
            default: ;
        endcase
        return cw;
    endfunction

    initial begin
        int nacc;
        int base;
        logic [37:0] cw;
        rst = 1'b1;
        req0_valid = 1'b0; req0_cw = '0;
        req1_valid = 1'b0; req1_cw = '0;
        resp_ready = 1'b0; clr_cnt = 1'b0;
        m_last = 1'b1; m_cc = 0; m_uc = 0;
        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            step(1'b1, rnd_cw(), 1'b1, rnd_cw(), 1'b1, 1'b0);
            chk("arb_g0", o_r0, (i % 2) == 0);
            chk("arb_g1", o_r1, (i % 2) == 1);
        end
        repeat (3) idle(1'b1);

        step(1'b1, enc(32'hDEADBEEF), 1'b0, '0, 1'b1, 1'b0);
        base = m_cc;
        idle(1'b1);
        chk("clean_lat1", o_rv, 1'b0);
        idle(1'b1);
        chk("clean_rv", o_rv, 1'b1);
        chk("clean_data", o_d, 32'hDEADBEEF);
        chk("clean_flags", {o_id, o_c, o_u, o_syn}, 9'h0);
        idle(1'b1);
        chk("clean_cnt", o_cc, 16'(base));

        cw = enc(32'h12345678);
        cw[5] = ~cw[5];
        step(1'b1, cw, 1'b0, '0, 1'b1, 1'b0);
        base = o_cc;
        idle(1'b1);
        idle(1'b1);
        chk("sbe_data", o_d, 32'h12345678);
        chk("sbe_syn", o_syn, 6'd6);
        chk("sbe_corr", o_c, 1'b1);
        idle(1'b1);
        chk("sbe_cnt", o_cc, 16'(base + 1));

        cw = enc(32'h0);
        cw[31] = ~cw[31];
        step(1'b0, '0, 1'b1, cw, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("par_data", o_d, 32'h0);
        chk("par_syn", o_syn, 6'd32);
        chk("par_id", o_id, 1'b1);
        chk("par_corr", o_c, 1'b1);

        cw[6] = ~cw[6];
        base = o_uc;
        nacc = o_cc + 1;
        step(1'b1, cw, 1'b0, '0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("unc_syn", o_syn, 6'd39);
        chk("unc_flag", {o_c, o_u}, 2'b01);
        idle(1'b1);
        chk("unc_cnt", o_uc, 16'(base + 1));
        chk("unc_ccnt", o_cc, 16'(nacc));

        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_cw(), 1'b1, rnd_cw(), 1'b0, 1'b0);
            nacc += int'(o_r0) + int'(o_r1);
        end
        chk("bp_accepts", nacc, 2);
        chk("bp_rdy_low", {o_r0, o_r1}, 2'b00);
        repeat (4) idle(1'b1);

        cw = enc(32'hCAFE0123);
        cw[3] = ~cw[3];
        step(1'b1, cw, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("clr_hs_corr", {o_rv, o_c}, 2'b11);
        idle(1'b1);
        chk("clr_cnt", o_cc, 16'h0);

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            step($urandom_range(0, 2) != 0, rnd_cw(),
                 $urandom_range(0, 2) != 0, rnd_cw(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        repeat (4) idle(1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
